// File: rtl/mccu_quota_refill.sv
// ============================================================================
// Module   : mccu_quota_refill
// Purpose  : Periodic quota replenishment controller for the MCCU. It reloads
//            the per-core budgets every period and turns MCCU quota
//            interruptions into stall requests, sticky IRQs and saturating
//            overrun counts.
// Options  : MCCU_REFILL_CARRY_EN - on a reload from RUN, carry the unused
//            remaining quota into the next period (saturating sum).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mccu_quota_refill #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned N_CORES      = 2,
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned OVR_WIDTH    = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 enable_i,
  input  logic [PERIOD_WIDTH-1:0]              period_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0]   budget_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0]   quota_remaining_i,
  input  logic [N_CORES-1:0]                   interruption_quota_i,
  input  logic [N_CORES-1:0]                   irq_ack_i,
  output logic [N_CORES-1:0][DATA_WIDTH-1:0]   quota_o,
  output logic                                 mccu_enable_o,
  output logic [N_CORES-1:0]                   stall_o,
  output logic [N_CORES-1:0]                   irq_o,
  output logic [N_CORES-1:0][OVR_WIDTH-1:0]    overrun_cnt_o,
  output logic                                 period_done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                             state;
  state_t                             state_nxt;
  logic [PERIOD_WIDTH-1:0]            period_lat;
  logic [PERIOD_WIDTH-1:0]            count;
  logic [N_CORES-1:0]                 exhaust_set;
  logic [N_CORES-1:0][DATA_WIDTH-1:0] quota_nxt;

`ifdef MCCU_REFILL_CARRY_EN
  logic [N_CORES-1:0][DATA_WIDTH:0]   carry_sum;
`else
  // The remaining quota only matters when carry-over is built in.
  logic                               unused_remaining;
  assign unused_remaining = ^quota_remaining_i;
`endif

  // Next-state selection; dropping enable_i wins over every other transition.
  always_comb begin
    state_nxt   = state;
    exhaust_set = '0;
    case (state)
      IDLE:    if (enable_i) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (count == '0) state_nxt = LOAD;
        // Only a fresh exhaustion in RUN counts as an overrun event.
        exhaust_set = interruption_quota_i & ~stall_o;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable_i) state_nxt = IDLE;
  end

  // Quota presented during LOAD: budget, optionally plus the carried remainder.
  always_comb begin
    quota_nxt = budget_i;
`ifdef MCCU_REFILL_CARRY_EN
    carry_sum = '0;
    if (state == RUN) begin
      for (int i = 0; i < int'(N_CORES); i++) begin
        carry_sum[i] = {1'b0, budget_i[i]} + {1'b0, quota_remaining_i[i]};
        quota_nxt[i] = carry_sum[i][DATA_WIDTH] ? {DATA_WIDTH{1'b1}}
                                                : carry_sum[i][DATA_WIDTH-1:0];
      end
    end
`endif
  end

  // State, period counter, and all registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      period_lat    <= '0;
      count         <= '0;
      quota_o       <= '0;
      mccu_enable_o <= 1'b0;
      stall_o       <= '0;
      irq_o         <= '0;
      overrun_cnt_o <= '0;
      period_done_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      mccu_enable_o <= (state_nxt == RUN);
      period_done_o <= (state == RUN) && (state_nxt == LOAD);

      if (state_nxt == LOAD) begin
        quota_o    <= quota_nxt;
        period_lat <= period_i;
      end

      // RUN spans max(period,1) cycles: load period-1, leave RUN at zero.
      if (state_nxt != RUN)
        count <= '0;
      else if (state == LOAD)
        count <= (period_lat == '0) ? '0 : period_lat - 1'b1;
      else
        count <= count - 1'b1;

      // Exhaustion is per period: any reload or idle clears the stall.
      stall_o <= (state_nxt == RUN) ? (stall_o | exhaust_set) : '0;

      // A new overrun beats a same-cycle acknowledge.
      irq_o <= exhaust_set | (irq_o & ~irq_ack_i);

      for (int i = 0; i < int'(N_CORES); i++) begin
        if (exhaust_set[i] && (overrun_cnt_o[i] != {OVR_WIDTH{1'b1}}))
          overrun_cnt_o[i] <= overrun_cnt_o[i] + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mccu_quota_refill.sv
// ============================================================================
// Module   : tb_mccu_quota_refill
// Purpose  : Scoreboard bench for mccu_quota_refill. Stimulus pushes the
//            expected output values for the current cycle; a monitor on the
//            falling edge pops and compares them. Carry expectations follow
//            MCCU_REFILL_CARRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mccu_quota_refill;

  localparam int DW  = 32;
  localparam int NC  = 2;
  localparam int PW  = 32;
  localparam int OW  = 4;
  localparam int OVR_MAX = 15;

  localparam int S_QUOTA = 0;
  localparam int S_MEN   = 1;
  localparam int S_STALL = 2;
  localparam int S_IRQ   = 3;
  localparam int S_OVR   = 4;
  localparam int S_PD    = 5;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      enable = 1'b0;
  logic [PW-1:0]             period = '0;
  logic [NC-1:0][DW-1:0]     budget = '0;
  logic [NC-1:0][DW-1:0]     remaining = '0;
  logic [NC-1:0]             intr = '0;
  logic [NC-1:0]             ack = '0;
  logic [NC-1:0][DW-1:0]     quota;
  logic                      men;
  logic [NC-1:0]             stall;
  logic [NC-1:0]             irq;
  logic [NC-1:0][OW-1:0]     ovr;
  logic                      pd;

  mccu_quota_refill #(
    .DATA_WIDTH  (DW),
    .N_CORES     (NC),
    .PERIOD_WIDTH(PW),
    .OVR_WIDTH   (OW)
  ) dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .enable_i            (enable),
    .period_i            (period),
    .budget_i            (budget),
    .quota_remaining_i   (remaining),
    .interruption_quota_i(intr),
    .irq_ack_i           (ack),
    .quota_o             (quota),
    .mccu_enable_o       (men),
    .stall_o             (stall),
    .irq_o               (irq),
    .overrun_cnt_o       (ovr),
    .period_done_o       (pd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sig;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sig, int idx);
    case (sig)
      S_QUOTA: return quota[idx];
      S_MEN:   return {31'd0, men};
      S_STALL: return {31'd0, stall[idx]};
      S_IRQ:   return {31'd0, irq[idx]};
      S_OVR:   return 32'(ovr[idx]);
      default: return {31'd0, pd};
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.sig, e.idx);
      n_checks++;
      if (e.cyc != cyc)
        $display("FAIL %s: check missed its cycle (queued %0d, now %0d)", e.name, e.cyc, cyc);
      else if (a !== e.val)
        $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", e.name, e.idx, cyc, a, e.val);
      else
        n_pass++;
    end
  end

  task automatic expect_now(int sig, int idx, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.idx = idx; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(string nm);
    for (int i = 0; i < NC; i++) begin
      expect_now(S_QUOTA, i, 32'd0, {nm, "_quota"});
      expect_now(S_STALL, i, 32'd0, {nm, "_stall"});
      expect_now(S_IRQ,   i, 32'd0, {nm, "_irq"});
      expect_now(S_OVR,   i, 32'd0, {nm, "_ovr"});
    end
    expect_now(S_MEN, 0, 32'd0, {nm, "_men"});
    expect_now(S_PD,  0, 32'd0, {nm, "_pd"});
  endtask

  // Advance one clock; inputs set afterwards are sampled on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then released with the block disabled.
    repeat (3) tick();
    expect_all_zero("in_reset");
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      expect_now(S_PD,  0, 32'd0, "idle_pd");
      expect_now(S_MEN, 0, 32'd0, "idle_men");
    end
    expect_all_zero("after_reset");

    // Basic cadence: period 4 -> LOAD + 4 RUN, repeating.
    period = 4;
    budget[0] = 100;
    budget[1] = 200;
    enable = 1'b1;
    tick();
    expect_now(S_MEN,   0, 32'd0,   "first_load_men");
    expect_now(S_PD,    0, 32'd0,   "first_load_pd");
    expect_now(S_QUOTA, 0, 32'd100, "load_quota");
    expect_now(S_QUOTA, 1, 32'd200, "load_quota");
    for (int k = 1; k <= 15; k++) begin
      tick();
      expect_now(S_PD,  0, (k % 5 == 0) ? 32'd1 : 32'd0, "cadence_pd");
      expect_now(S_MEN, 0, (k % 5 == 0) ? 32'd0 : 32'd1, "cadence_men");
    end
    expect_now(S_QUOTA, 1, 32'd200, "cadence_quota");
    enable = 1'b0;
    tick();
    expect_now(S_MEN, 0, 32'd0, "disable_men");

    // Exhaustion on core 0 with period 10.
    period = 10;
    enable = 1'b1;
    tick();                                   // LOAD
    tick();                                   // RUN, count 9
    tick();                                   // RUN, count 8
    intr[0] = 1'b1;
    tick();                                   // RUN: exhaustion sampled
    intr[0] = 1'b0;
    expect_now(S_STALL, 0, 32'd1, "exh_stall0");
    expect_now(S_STALL, 1, 32'd0, "exh_stall1");
    expect_now(S_IRQ,   0, 32'd1, "exh_irq0");
    expect_now(S_OVR,   0, 32'd1, "exh_ovr0");
    intr[0] = 1'b1;
    tick();
    intr[0] = 1'b0;
    expect_now(S_OVR,   0, 32'd1, "repeat_ovr0");
    for (int k = 5; k <= 10; k++) begin
      tick();
      expect_now(S_STALL, 0, 32'd1, "hold_stall0");
    end
    tick();                                   // reload
    expect_now(S_PD,    0, 32'd1, "reload_pd");
    expect_now(S_STALL, 0, 32'd0, "reload_stall0");
    expect_now(S_IRQ,   0, 32'd1, "sticky_irq0");
    expect_now(S_OVR,   0, 32'd1, "reload_ovr0");
    ack[0] = 1'b1;
    tick();                                   // RUN, count 9
    ack[0] = 1'b0;
    expect_now(S_IRQ, 0, 32'd0, "ack_irq0");

    // Ack race on core 1.
    intr[1] = 1'b1;
    tick();
    intr[1] = 1'b0;
    expect_now(S_IRQ, 1, 32'd1, "set_irq1");
    expect_now(S_OVR, 1, 32'd1, "set_ovr1");
    repeat (9) tick();                        // through the final RUN edge
    expect_now(S_PD,    0, 32'd1, "race_reload_pd");
    expect_now(S_STALL, 1, 32'd0, "race_reload_stall1");
    tick();                                   // RUN
    intr[1] = 1'b1;
    ack[1]  = 1'b1;
    tick();
    intr[1] = 1'b0;
    expect_now(S_IRQ, 1, 32'd1, "race_irq1");
    expect_now(S_OVR, 1, 32'd2, "race_ovr1");
    tick();
    ack[1] = 1'b0;
    expect_now(S_IRQ, 1, 32'd0, "ack_only_irq1");

    // Enable dropped mid-RUN.
    intr[0] = 1'b1;
    tick();
    intr[0] = 1'b0;
    expect_now(S_OVR, 0, 32'd2, "midrun_ovr0");
    enable = 1'b0;
    tick();
    expect_now(S_MEN,   0, 32'd0, "drop_men");
    expect_now(S_STALL, 0, 32'd0, "drop_stall0");
    expect_now(S_IRQ,   0, 32'd1, "drop_irq0");
    expect_now(S_PD,    0, 32'd0, "drop_pd");

    // Period 0 acts as 1; exhaustion on the final RUN edge each period.
    period = 0;
    intr[1] = 1'b1;
    enable = 1'b1;
    tick();                                   // LOAD from IDLE
    expect_now(S_OVR, 1, 32'd2, "p0_load_ovr1");
    tick();                                   // RUN (single cycle)
    expect_now(S_MEN, 0, 32'd1, "p0_run_men");
    for (int k = 1; k <= 16; k++) begin
      tick();
      expect_now(S_PD,    0, 32'd1, "p0_pd");
      expect_now(S_MEN,   0, 32'd0, "p0_load_men");
      expect_now(S_STALL, 1, 32'd0, "p0_stall1");
      expect_now(S_OVR,   1, (k + 2 > OVR_MAX) ? OVR_MAX : k + 2, "sat_ovr1");
      tick();
      expect_now(S_MEN, 0, 32'd1, "p0_run_men");
    end
    expect_now(S_IRQ, 1, 32'd1, "p0_irq1");
    intr[1] = 1'b0;
    enable = 1'b0;
    tick();

    // Reload quota: from IDLE budget only, from RUN optionally with carry.
    budget[0] = 32'hFFFF_FFF0;
    budget[1] = 32'd50;
    remaining[0] = 32'h20;
    remaining[1] = 32'd7;
    period = 2;
    enable = 1'b1;
    tick();
    expect_now(S_QUOTA, 0, 32'hFFFF_FFF0, "idle_load_q0");
    expect_now(S_QUOTA, 1, 32'd50,        "idle_load_q1");
    repeat (3) tick();
    expect_now(S_PD, 0, 32'd1, "carry_reload_pd");
`ifdef MCCU_REFILL_CARRY_EN
    expect_now(S_QUOTA, 0, 32'hFFFF_FFFF, "carry_sat_q0");
    expect_now(S_QUOTA, 1, 32'd57,        "carry_sum_q1");
`else
    expect_now(S_QUOTA, 0, 32'hFFFF_FFF0, "nocarry_q0");
    expect_now(S_QUOTA, 1, 32'd50,        "nocarry_q1");
`endif

    // Asynchronous reset in the middle of RUN.
    tick();                                   // RUN
    #2;
    rstn = 1'b0;
    expect_all_zero("async_reset");
    tick();
    rstn = 1'b1;
    enable = 1'b0;
    tick();
    tick();

    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mccu_quota_refill.md
# mccu_quota_refill

Periodic quota replenishment controller paired with the MCCU. It drives the MCCU's quota inputs and enable, and reloads each core's contention budget at a fixed period. It consumes the MCCU's per-core quota interruptions and turns them into sticky, software-acknowledged IRQs, per-core stall requests and saturating overrun statistics. It sits between the AXI-lite register file, which supplies period and budgets, and the MCCU instance.

## Interface
- DATA_WIDTH, 32, width of quota/budget values (matches MCCU)
- N_CORES, 2, number of monitored cores
- PERIOD_WIDTH, 32, width of the replenish period counter
- OVR_WIDTH, 16, width of per-core overrun counters
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  block enable, active high
- period_i  in  PERIOD_WIDTH  replenish period in cycles; 0 treated as 1
- budget_i  in  [N_CORES] x DATA_WIDTH  per-core budget loaded each period
- quota_remaining_i  in  [N_CORES] x DATA_WIDTH  MCCU remaining quota (MCCU quota_o)
- interruption_quota_i  in  [N_CORES] x 1  MCCU quota interruption
- irq_ack_i  in  [N_CORES] x 1  software acknowledge, one-cycle pulse
- quota_o  out  [N_CORES] x DATA_WIDTH  to MCCU quota_i
- mccu_enable_o  out  1  to MCCU enable_i
- stall_o  out  [N_CORES] x 1  throttle request to core
- irq_o  out  [N_CORES] x 1  sticky overrun interrupt
- overrun_cnt_o  out  [N_CORES] x OVR_WIDTH  periods in which the core exhausted quota
- period_done_o  out  1  one-cycle pulse per reload

## Operation
- Global FSM with states IDLE, LOAD and RUN. All outputs are registered.
- IDLE: mccu_enable_o=0, stall_o=0. If enable_i=1, go to LOAD.
- LOAD (exactly 1 cycle):
  - mccu_enable_o=0, so the MCCU copies quota_o into its quota register.
  - quota_o[i] = budget_i[i], sampled on the edge entering LOAD.
  - period_i is latched on the same edge.
  - period_done_o=1 only when LOAD was entered from RUN.
  - Go to RUN.
- RUN:
  - mccu_enable_o=1. The down-counter is loaded with max(period_i,1)-1 on LOAD->RUN and decrements each cycle.
  - At count 0, go to LOAD.
  - enable_i=0 in any state goes to IDLE on the next edge.
- Per-core exhausted flag:
  - Set on any RUN-state edge where interruption_quota_i[i]=1.
  - Cleared on the edge entering LOAD or IDLE.
  - stall_o[i] equals the exhausted flag.
- Overrun counter: overrun_cnt_o[i] increments once, on the edge where exhausted[i] goes 0->1. It saturates at all-ones and clears only on reset.
- irq_o[i]:
  - Set with exhausted 0->1 and held across periods and IDLE.
  - Cleared by irq_ack_i[i].
  - A simultaneous set and ack leaves it set.
- interruption_quota_i is ignored in IDLE and LOAD.

## Timing
- Reset values: quota_o=0, mccu_enable_o=0, stall_o=0, irq_o=0, overrun_cnt_o=0, period_done_o=0, state IDLE, counter 0.
- enable_i sampled high at edge N: LOAD during cycle N..N+1, RUN from edge N+1.
- RUN lasts exactly max(period_i,1) cycles. Reload cadence is max(period_i,1)+1 cycles, including the LOAD cycle.
- Interruption sampled at edge N: stall_o/irq_o high after edge N, i.e. 1-cycle latency.
- Exhausted at the final RUN edge: stall_o is not asserted (LOAD clears it). The overrun is still counted and irq_o is still set.
- Changes to period_i or budget_i take effect only at the next LOAD.
- Asynchronous reset mid-RUN returns all registers to reset values immediately.

## Configuration
- MCCU_REFILL_CARRY_EN defined:
  - quota_o[i] = budget_i[i] + quota_remaining_i[i], with quota_remaining_i sampled on the RUN->LOAD edge.
  - The sum is computed DATA_WIDTH+1 wide and saturates to all-ones.
  - Entry from IDLE loads budget_i only.
- Not defined: quota_o[i] = budget_i[i] always, and quota_remaining_i is unused.

## Test plan
- Reset check: rstn_i low then high, enable_i=0 for 10 cycles -> all outputs 0, state IDLE, no period_done_o.
- Basic cadence: period_i=4, budget_i={100,200}, enable_i=1 -> LOAD then 4 RUN cycles, repeating. period_done_o pulses every 5 cycles after the first LOAD. quota_o={100,200}. mccu_enable_o low exactly in LOAD cycles.
- Exhaustion: period_i=10, interruption_quota_i[0] pulsed at RUN cycle 3 -> stall_o[0]=1 from cycle 4 until the next LOAD. irq_o[0]=1 and stays set. overrun_cnt_o[0]=1. Repeated pulses in the same period leave the count at 1.
- Ack race: irq_o[1] set, and irq_ack_i[1] coincides with a new exhaustion event -> irq_o[1] stays 1. An ack alone on the next cycle -> irq_o[1]=0.
- Saturation and boundaries:
  - period_i=0 -> RUN lasts 1 cycle.
  - overrun_cnt_o preloaded to near 0xFFFF via repeated periods -> holds at 0xFFFF.
  - enable_i dropped mid-RUN -> IDLE next edge, stall_o=0, irq_o retained.
- Carry (with MCCU_REFILL_CARRY_EN): budget 0xFFFFFFF0, quota_remaining_i=0x20 at reload -> quota_o=0xFFFFFFFF. budget 50, remaining 7 -> quota_o=57.
